// File: rtl/glb_stream_capture.sv
// Capture engine for GLB read streams: NUM_BLOCKS length-prefixed blocks are
// taken over a ready/valid channel, each into its own bank, with a registered readback port.
module glb_stream_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BLOCKS = 2,
  parameter int DEPTH      = 1024,
  parameter int LEN_W      = $clog2(DEPTH + 1),
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        done,
  output logic [1:0]                  blk_idx,
  output logic                        err_overflow,
  output logic [NUM_BLOCKS*LEN_W-1:0] block_len,
  input  logic                        rd_en,
  input  logic [1:0]                  rd_block,
  input  logic [AW-1:0]               rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HDR, S_BODY, S_DONE} state_t;

  localparam logic [DATA_WIDTH:0] DEPTH_W = (DATA_WIDTH + 1)'(DEPTH);

  state_t                  r_state, w_next;
  logic                    r_ready, r_done, r_err;
  logic [1:0]              r_blk_idx;
  logic [NUM_BLOCKS*LEN_W-1:0] r_block_len;
  logic [DATA_WIDTH-1:0]   r_hdr, r_wr_cnt;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;

  logic                    w_xfer, w_last, w_blk_end, w_we;
  logic [DATA_WIDTH-1:0]   w_cnt_inc;
  logic [LEN_W-1:0]        w_len;
  logic [DATA_WIDTH-1:0]   w_bank_q [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0]   w_rd_word;

  // A transfer coincident with a flush edge is dropped.
  assign w_xfer    = r_ready && valid && !flush;
  assign w_last    = (r_blk_idx == 2'(NUM_BLOCKS - 1));
  assign w_cnt_inc = r_wr_cnt + 1'b1;
  assign w_blk_end = (r_state == S_BODY) && w_xfer && (w_cnt_inc == r_hdr);
  assign w_len     = ({1'b0, r_hdr} > DEPTH_W) ? LEN_W'(DEPTH) : r_hdr[LEN_W-1:0];
  assign w_we      = (r_state == S_BODY) && w_xfer && ({1'b0, r_wr_cnt} < DEPTH_W);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (flush) w_next = S_ARMED;
      S_ARMED: if (!flush) w_next = S_HDR;
      S_HDR:   if (w_xfer) begin
                 if (data == '0) w_next = w_last ? S_DONE : S_HDR;
                 else            w_next = S_BODY;
               end
      S_BODY:  if (w_blk_end) w_next = w_last ? S_DONE : S_HDR;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_ARMED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_HDR) || (w_next == S_BODY);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_idx   <= '0;
      r_block_len <= '0;
      r_err       <= 1'b0;
      r_hdr       <= '0;
      r_wr_cnt    <= '0;
    end else if (flush || r_state == S_ARMED) begin
      r_blk_idx   <= '0;
      r_block_len <= '0;
      r_err       <= 1'b0;
      r_hdr       <= '0;
      r_wr_cnt    <= '0;
    end else if (w_xfer && r_state == S_HDR) begin
      r_hdr    <= data;
      r_wr_cnt <= '0;
      if ({1'b0, data} > DEPTH_W) r_err <= 1'b1;
      if (data == '0) begin
        r_block_len[r_blk_idx*LEN_W +: LEN_W] <= '0;
        if (!w_last) r_blk_idx <= r_blk_idx + 2'd1;
      end
    end else if (w_xfer && r_state == S_BODY) begin
      r_wr_cnt <= w_cnt_inc;
      if (w_blk_end) begin
        r_block_len[r_blk_idx*LEN_W +: LEN_W] <= w_len;
        if (!w_last) r_blk_idx <= r_blk_idx + 2'd1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (w_we && r_blk_idx == 2'(b)) r_mem[r_wr_cnt[AW-1:0]] <= data;
    end
    assign w_bank_q[b] = r_mem[rd_addr];
  end

  // Out-of-range banks read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if (rd_block == 2'(b)) w_rd_word = w_bank_q[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_word;
    end
  end

  assign ready        = r_ready;
  assign done         = r_done;
  assign blk_idx      = r_blk_idx;
  assign err_overflow = r_err;
  assign block_len    = r_block_len;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_glb_stream_capture.sv
// Directed bench for glb_stream_capture (NUM_BLOCKS=2, DEPTH=8) with
// hand-computed expectations checked by immediate assertions.
module tb_glb_stream_capture;

  localparam int DW = 16;
  localparam int NB = 2;
  localparam int DEPTH = 8;
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst, flush, valid, rd_en;
  logic [DW-1:0]     data;
  logic              ready, done, err_overflow, rd_valid;
  logic [1:0]        blk_idx, rd_block;
  logic [NB*LEN_W-1:0] block_len;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;

  int vec = 0;
  int miss = 0;

  glb_stream_capture #(.DATA_WIDTH(DW), .NUM_BLOCKS(NB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .data(data), .valid(valid),
    .ready(ready), .done(done), .blk_idx(blk_idx), .err_overflow(err_overflow),
    .block_len(block_len), .rd_en(rd_en), .rd_block(rd_block), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns 1ns after the edge that transfers it; valid stays high.
  task automatic send(input logic [DW-1:0] w);
    int n;
    n = 0;
    data  = w;
    valid = 1'b1;
    @(negedge clk);
    while (!ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready) begin
      vec++;
      miss++;
      $error("FAIL send_timeout observed=ready_low expected=ready_high word=%0h", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_flush();
    valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] b, input logic [AW-1:0] a,
                    input logic [DW-1:0] exp);
    rd_en = 1'b1;
    rd_block = b;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; data = '0;
    rd_en = 1'b0; rd_block = '0; rd_addr = '0;
    #12;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_blk_idx", 32'(blk_idx), 0);
    chk("rst_err", 32'(err_overflow), 0);
    chk("rst_block_len", 32'(block_len), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(ready), 0);

    // Session A: gapped first block, back-to-back second block.
    pulse_flush();
    chk("armed_ready", 32'(ready), 0);
    tick();
    chk("hdr_ready", 32'(ready), 1);
    send(16'd3);
    gap(2);
    send(16'd1);
    gap(1);
    send(16'd2);
    send(16'd3);
    chk("a_adv_ready", 32'(ready), 1);
    chk("a_adv_blk", 32'(blk_idx), 1);
    send(16'd2);
    send(16'd9);
    send(16'd8);
    valid = 1'b0;
    chk("a_done", 32'(done), 1);
    chk("a_done_ready", 32'(ready), 0);
    chk("a_len", 32'(block_len), 32'h23);
    rd("a_b0a0", 2'd0, 3'd0, 16'd1);
    rd("a_b0a1", 2'd0, 3'd1, 16'd2);
    rd("a_b0a2", 2'd0, 3'd2, 16'd3);
    rd("a_b1a0", 2'd1, 3'd0, 16'd9);
    rd("a_b1a1", 2'd1, 3'd1, 16'd8);
    tick();
    chk("rd_idle_valid", 32'(rd_valid), 0);
    chk("rd_hold_data", 32'(rd_data), 32'd8);
    rd("a_oob", 2'd2, 3'd0, 16'd0);

    // Session B: zero-length block 0.
    pulse_flush();
    chk("b_flush_done", 32'(done), 0);
    chk("b_flush_len", 32'(block_len), 0);
    send(16'd0);
    chk("b_zero_blk", 32'(blk_idx), 1);
    send(16'd1);
    send(16'h0005);
    valid = 1'b0;
    chk("b_done", 32'(done), 1);
    chk("b_len", 32'(block_len), 32'h10);
    rd("b_b1a0", 2'd1, 3'd0, 16'h0005);

    // Session C: header larger than DEPTH.
    pulse_flush();
    send(16'd10);
    chk("c_err", 32'(err_overflow), 1);
    for (int i = 0; i < 10; i++) send(16'(i));
    chk("c_consumed_blk", 32'(blk_idx), 1);
    chk("c_consumed_ready", 32'(ready), 1);
    send(16'd1);
    send(16'h0055);
    valid = 1'b0;
    chk("c_done", 32'(done), 1);
    chk("c_len", 32'(block_len), 32'h18);
    chk("c_err_sticky", 32'(err_overflow), 1);
    rd("c_b0a0", 2'd0, 3'd0, 16'd0);
    rd("c_b0a7", 2'd0, 3'd7, 16'd7);
    rd("c_b1a0", 2'd1, 3'd0, 16'h0055);

    // Session D: flush mid-body with a coincident transfer that must be dropped.
    pulse_flush();
    send(16'd5);
    send(16'h000A);
    send(16'h000B);
    data = 16'h000C;
    valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    chk("d_flush_ready", 32'(ready), 0);
    chk("d_flush_len", 32'(block_len), 0);
    chk("d_flush_err", 32'(err_overflow), 0);
    rd("d_b0a2_kept", 2'd0, 3'd2, 16'd2);
    rd("d_b0a1_partial", 2'd0, 3'd1, 16'h000B);
    send(16'd2);
    send(16'd7);
    send(16'd7);
    chk("d_len", 32'(block_len), 32'h02);
    chk("d_blk", 32'(blk_idx), 1);
    chk("d_not_done", 32'(done), 0);

    // Async reset mid-body.
    send(16'd12);
    chk("e_err", 32'(err_overflow), 1);
    send(16'h0011);
    #3;
    rst = 1'b1;
    #1;
    valid = 1'b0;
    chk("e_rst_ready", 32'(ready), 0);
    chk("e_rst_err", 32'(err_overflow), 0);
    chk("e_rst_done", 32'(done), 0);
    chk("e_rst_len", 32'(block_len), 0);
    chk("e_rst_blk", 32'(blk_idx), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("e_idle_ready", 32'(ready), 0);
    pulse_flush();
    send(16'd1);
    send(16'h0033);
    send(16'd1);
    send(16'h0044);
    valid = 1'b0;
    chk("e_done", 32'(done), 1);
    chk("e_len", 32'(block_len), 32'h11);
    rd("e_b0a0", 2'd0, 3'd0, 16'h0033);
    rd("e_b1a0", 2'd1, 3'd0, 16'h0044);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
